gcn_transform_sched: RTL and testbench
======================================

Name: gcn_transform_sched

Overview:
- Sequencer for the GCN transformation phase (feature matrix x weight matrix).
- Issues single-port memory reads for weight columns and feature rows, then strobes the load registers of the dot-product datapath.
- Handshakes with the MAC unit and emits write strobes that index the FEATURE_ROWS x WEIGHT_COLS result buffer.
- Sits between the GCN top-level start/done and the transformation datapath; the combination/argmax stage consumes its done.

Parameters:
- FEATURE_ROWS, 6, number of feature rows (graph nodes)
- WEIGHT_COLS, 3, number of weight columns (output classes)
- ADDRESS_WIDTH, 13, memory read-address width
- FEATURE_BASE, 512, address of feature row 0 (weight column c lives at address c)
- COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS), row index width
- COUNTER_WEIGHT_WIDTH, $clog2(WEIGHT_COLS), column index width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; run begins on rising edge of clk in IDLE with start=1
- enable_read  out  1  memory read request
- read_address  out  ADDRESS_WIDTH  memory address, valid while enable_read=1
- load_weight  out  1  latch data_in into datapath weight register
- load_feature  out  1  latch data_in into datapath feature register
- mac_start  out  1  one-cycle pulse starting a dot product
- mac_done  in  1  dot-product result valid (sampled only in WAIT)
- wr_en  out  1  write result buffer entry
- wr_row  out  COUNTER_FEATURE_WIDTH  buffer row index
- wr_col  out  COUNTER_WEIGHT_WIDTH  buffer column index
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  transformation complete

Behaviour:
- Reset: the asynchronous, active-high reset forces state IDLE, row=0, col=0, and all outputs 0.
- Reset asserted mid-run aborts immediately, with no partial write.
- Memory read latency is one cycle: data_in is valid in the cycle following the enable_read cycle.
- All outputs are registered-state decodes (Moore). wr_row = row, wr_col = col at all times.
- State transitions:
  - IDLE: start=1 -> RD_W. Otherwise stay.
  - RD_W: enable_read=1, read_address=col -> LD_W.
  - LD_W: load_weight=1 -> RD_F.
  - RD_F: enable_read=1, read_address=FEATURE_BASE+row -> LD_F.
  - LD_F: load_feature=1 -> MAC.
  - MAC: mac_start=1 -> WAIT.
  - WAIT: stay until mac_done=1 -> WR. No timeout. mac_done seen in any other state is ignored.
  - WR: wr_en=1, then:
    - if row<FEATURE_ROWS-1: row++ -> RD_F;
    - else if col<WEIGHT_COLS-1: row=0, col++ -> RD_W;
    - else row=0, col=0 -> DONE.
  - DONE: done=1. start=0 -> IDLE. start held high keeps DONE (no auto-restart).
- start is ignored in all busy states.
- Loop order is column-outer / row-inner, so each weight column is fetched once.
- Counters wrap explicitly at FEATURE_ROWS-1 / WEIGHT_COLS-1 and never reach the unused encodings.
- Cycle count, from the first cycle of RD_W to the first cycle of DONE, with MAC latency k (mac_done in the k-th WAIT cycle):
  - WEIGHT_COLS*(2 + FEATURE_ROWS*(4+k)) cycles.
  - Defaults with k=1: 96 cycles.
- At most one of enable_read, load_weight, load_feature, mac_start, wr_en is high in any cycle.

Optional Feature:
- Macro: GCN_SCHED_PERF_EN.
- Defined:
  - Adds output cycle_count [15:0]. It clears on the IDLE->RD_W transition and increments every cycle while busy=1.
  - The count saturates at 16'hFFFF, holds its value in DONE, and is cleared by reset.
- Undefined: no port and no counter logic; the remaining behaviour is identical.

Decomposition:
- Package gcn_sched_pkg holds:
  - typedef enum logic [3:0] sched_state_t {IDLE, RD_W, LD_W, RD_F, LD_F, MAC, WAIT, WR, DONE};
  - localparam FEATURE_BASE_DEFAULT = 512.
- Single module, with no sub-module. The optional perf counter is an inline always_ff block under the macro.

Test Plan:
- Reset/start, mac_done returned in the first WAIT cycle: reads go to address 0, 512..517, 1, 512..517, 2, 512..517, in that order. 18 wr_en pulses with (row,col) = (0,0)..(5,0)..(5,2). done rises 96 cycles after RD_W.
- Variable MAC latency: mac_done delayed 0..4 random cycles. wr_en is never asserted before mac_done; no extra or missing writes; total = 3*(2+6*(4+k_i)) summed over k_i.
- Spurious mac_done held high in RD_F/LD_F/MAC: no state skip; exactly one wr_en per (row,col).
- start held high after completion: done stays 1 and no new reads occur. Dropping start returns to IDLE with done=0. Reasserting start repeats the identical 96-cycle sequence.
- Reset asserted in WAIT at (row=3,col=1): all outputs are 0 in the same cycle, without waiting for a clock edge. After release with start=1 the run restarts at address 0.
- GCN_SCHED_PERF_EN defined, k=1: cycle_count=96 while in DONE, and it clears on the next start.

Source files
------------

// File: rtl/gcn_sched_pkg.sv
// Shared types and defaults for the GCN transformation-phase sequencer.
package gcn_sched_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_W,
        LD_W,
        RD_F,
        LD_F,
        MAC,
        WAIT,
        WR,
        DONE
    } sched_state_t;

    localparam int FEATURE_BASE_DEFAULT = 512;

endpackage

// File: rtl/gcn_transform_sched.sv
// Sequencer for feature x weight: fetches operands, drives the MAC, indexes the result buffer.
// Optional cycle counter enabled by defining GCN_SCHED_PERF_EN.
module gcn_transform_sched
    import gcn_sched_pkg::*;
#(
    parameter int FEATURE_ROWS          = 6,
    parameter int WEIGHT_COLS           = 3,
    parameter int ADDRESS_WIDTH         = 13,
    parameter int FEATURE_BASE          = FEATURE_BASE_DEFAULT,
    parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
    parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             enable_read,
    output logic [ADDRESS_WIDTH-1:0]         read_address,
    output logic                             load_weight,
    output logic                             load_feature,
    output logic                             mac_start,
    input  logic                             mac_done,
    output logic                             wr_en,
    output logic [COUNTER_FEATURE_WIDTH-1:0] wr_row,
    output logic [COUNTER_WEIGHT_WIDTH-1:0]  wr_col,
    output logic                             busy,
`ifdef GCN_SCHED_PERF_EN
    output logic                             done,
    output logic [15:0]                      cycle_count
`else
    output logic                             done
`endif
);

    localparam logic [COUNTER_FEATURE_WIDTH-1:0] ROW_LAST = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  COL_LAST = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);

    sched_state_t                     state;
    logic [COUNTER_FEATURE_WIDTH-1:0] row;
    logic [COUNTER_WEIGHT_WIDTH-1:0]  col;

    // Column-outer / row-inner so each weight column is fetched exactly once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= RD_W;
                RD_W: state <= LD_W;
                LD_W: state <= RD_F;
                RD_F: state <= LD_F;
                LD_F: state <= MAC;
                MAC:  state <= WAIT;
                WAIT: if (mac_done) state <= WR;
                WR: begin
                    if (row != ROW_LAST) begin
                        row   <= row + 1'b1;
                        state <= RD_F;
                    end else if (col != COL_LAST) begin
                        row   <= '0;
                        col   <= col + 1'b1;
                        state <= RD_W;
                    end else begin
                        row   <= '0;
                        col   <= '0;
                        state <= DONE;
                    end
                end
                DONE: if (!start) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Pure state decode, so an asynchronous reset clears every output at once.
    always_comb begin
        enable_read  = 1'b0;
        read_address = '0;
        load_weight  = 1'b0;
        load_feature = 1'b0;
        mac_start    = 1'b0;
        wr_en        = 1'b0;
        done         = 1'b0;
        busy         = (state != IDLE) && (state != DONE);
        case (state)
            RD_W: begin
                enable_read  = 1'b1;
                read_address = ADDRESS_WIDTH'(col);
            end
            LD_W: load_weight = 1'b1;
            RD_F: begin
                enable_read  = 1'b1;
                read_address = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(row);
            end
            LD_F: load_feature = 1'b1;
            MAC:  mac_start    = 1'b1;
            WR:   wr_en        = 1'b1;
            DONE: done         = 1'b1;
            default: ;
        endcase
    end

    assign wr_row = row;
    assign wr_col = col;

`ifdef GCN_SCHED_PERF_EN
    // Counts busy cycles of the current run; frozen once busy drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (state == IDLE && start) begin
            cycle_count <= '0;
        end else if (busy && cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gcn_transform_sched.sv
// Randomized self-checking bench for gcn_transform_sched against a loop-level reference model.
module tb_gcn_transform_sched;

    localparam int FR   = 6;
    localparam int WC   = 3;
    localparam int AW   = 13;
    localparam int BASE = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          enable_read;
    logic [AW-1:0] read_address;
    logic          load_weight;
    logic          load_feature;
    logic          mac_start;
    logic          mac_done;
    logic          wr_en;
    logic [2:0]    wr_row;
    logic [1:0]    wr_col;
    logic          busy;
    logic          done;
`ifdef GCN_SCHED_PERF_EN
    logic [15:0]   cycle_count;
`endif

    gcn_transform_sched dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .enable_read  (enable_read),
        .read_address (read_address),
        .load_weight  (load_weight),
        .load_feature (load_feature),
        .mac_start    (mac_start),
        .mac_done     (mac_done),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .busy         (busy),
`ifdef GCN_SCHED_PERF_EN
        .done         (done),
        .cycle_count  (cycle_count)
`else
        .done         (done)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Observations gathered by the monitor.
    int cyc = 0;
    int rd_q[$];
    int wr_q[$];
    int k_q[$];
    int kmode = 0;
    bit spur  = 1'b0;
    bit pend  = 1'b0;
    int widx, kcur, mstart_cyc;
    int gap_err, early_wr, onehot_err = 0;
    int rdw_cyc, done_cyc;
    int cc_at_rdw;
    bit busy_d = 1'b0, done_d = 1'b0;

    task automatic check(input string tag, input longint obs, input longint exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sample away from the active edge; also acts as the MAC responder.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            pend     = 1'b0;
            mac_done = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end else begin
            if (int'(enable_read) + int'(load_weight) + int'(load_feature) +
                int'(mac_start) + int'(wr_en) > 1) onehot_err++;
            if (enable_read) rd_q.push_back(int'(read_address));
            if (busy && !busy_d) begin
                rdw_cyc = cyc;
`ifdef GCN_SCHED_PERF_EN
                cc_at_rdw = int'(cycle_count);
`endif
            end
            if (done && !done_d) done_cyc = cyc;
            busy_d = busy;
            done_d = done;
            if (wr_en) begin
                wr_q.push_back(int'(wr_row) + 256 * int'(wr_col));
                if (!pend) early_wr++;
                else if (cyc - mstart_cyc != kcur + 1) gap_err++;
                pend = 1'b0;
            end
            mac_done = 1'b0;
            if (pend) begin
                widx++;
                mac_done = (widx == kcur);
            end
            if (mac_start) begin
                kcur = (kmode == 0) ? 1 : (kmode == 1) ? int'($urandom_range(1, 5)) : 5;
                k_q.push_back(kcur);
                pend       = 1'b1;
                widx       = 0;
                mstart_cyc = cyc;
            end
            if (spur && ((enable_read && int'(read_address) >= BASE) || load_feature || mac_start))
                mac_done = 1'b1;
        end
    end

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One full run; start is left high for the caller to manage.
    task automatic run(input int km, input bit sp, input string tag);
        bit ok;
        int exp_rd[$];
        int exp_wr[$];
        int mism;
        int exp_total;
        rd_q.delete(); wr_q.delete(); k_q.delete();
        kmode = km; spur = sp;
        gap_err = 0; early_wr = 0; done_cyc = -1; rdw_cyc = -1; cc_at_rdw = -1;
        start = 1'b1;
        wait_done(3000, ok);
        check({tag, "_finished"}, ok, 1);

        for (int c = 0; c < WC; c++) begin
            exp_rd.push_back(c);
            for (int r = 0; r < FR; r++) begin
                exp_rd.push_back(BASE + r);
                exp_wr.push_back(r + 256 * c);
            end
        end
        check({tag, "_rd_count"}, rd_q.size(), exp_rd.size());
        mism = 0;
        foreach (exp_rd[i]) if (i >= rd_q.size() || rd_q[i] != exp_rd[i]) mism++;
        check({tag, "_rd_seq_mismatches"}, mism, 0);
        check({tag, "_wr_count"}, wr_q.size(), exp_wr.size());
        mism = 0;
        foreach (exp_wr[i]) if (i >= wr_q.size() || wr_q[i] != exp_wr[i]) mism++;
        check({tag, "_wr_seq_mismatches"}, mism, 0);
        check({tag, "_mac_count"}, k_q.size(), FR * WC);

        exp_total = 2 * WC;
        foreach (k_q[i]) exp_total += 4 + k_q[i];
        check({tag, "_cycles"}, done_cyc - rdw_cyc, exp_total);
        check({tag, "_wr_before_mac_done"}, early_wr, 0);
        check({tag, "_mac_to_wr_gap_err"}, gap_err, 0);
`ifdef GCN_SCHED_PERF_EN
        check({tag, "_perf_clear"}, cc_at_rdw, 0);
        check({tag, "_perf_count"}, int'(cycle_count), exp_total);
`endif
    endtask

    task automatic idle_gap();
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("idle_after_drop", {busy, done}, 2'b00);
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        start = 1'b0;
        mac_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              {enable_read, read_address, load_weight, load_feature, mac_start, wr_en, busy, done}, 0);
        check("reset_rowcol", {wr_row, wr_col}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("idle_no_start", {busy, done, enable_read}, 3'b000);

        // Baseline k=1: expect 96 cycles.
        run(0, 1'b0, "base");
        check("base_total_96", done_cyc - rdw_cyc, 96);

        // start held high: stays in DONE, no new reads.
        repeat (20) @(negedge clk);
        #1;
        check("hold_done", {done, busy}, 2'b10);
        check("hold_no_reads", rd_q.size(), WC * (FR + 1));
        start = 1'b0;
        @(negedge clk); #1;
        check("drop_start_idle", {done, busy}, 2'b00);

        run(0, 1'b0, "rerun");
        check("rerun_total_96", done_cyc - rdw_cyc, 96);
        idle_gap();

        for (int i = 0; i < 3; i++) begin
            run(1, 1'b0, $sformatf("lat%0d", i));
            idle_gap();
        end

        run(1, 1'b1, "spur");
        idle_gap();

        // Abort in WAIT at row 3, col 1.
        kmode = 2; spur = 1'b0;
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (mac_start && wr_row == 3'd3 && wr_col == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_point_reached", found, 1);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("abort_outputs",
              {enable_read, read_address, load_weight, load_feature, mac_start, wr_en, busy, done}, 0);
        check("abort_rowcol", {wr_row, wr_col}, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        run(0, 1'b0, "post_abort");
        start = 1'b0;

        check("strobe_onehot_violations", onehot_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
